toggle_reg_bank: RTL and testbench
==================================

// Module: toggle_reg_bank
//
// PURPOSE
//   Parametrised successor to the single-bit invert/hold register.
//   A WIDTH-bit state register with per-bit masked operations: hold, invert, masked load, rotate.
//   Also keeps a saturating count of invert events and a one-cycle "changed" flag.
//   Used as a general control/status flop bank between combinational logic and downstream consumers.
//
// PARAMETERS
//   WIDTH      8  state register width (>=1)
//   INIT       0  value of O after reset (WIDTH bits)
//   CNT_WIDTH  8  width of invert-event counter (>=1)
//
// PORTS
//   CLK           in   1          clock, all state updates on rising edge
//   RESET         in   1          synchronous active-high reset
//   en            in   1          operation enable; 0 = hold all state
//   mode          in   2          00 HOLD, 01 INVERT, 10 LOAD, 11 ROTATE
//   mask          in   WIDTH      per-bit select for INVERT/LOAD; ignored for HOLD/ROTATE
//   load_data     in   WIDTH      data for LOAD
//   cnt_clr       in   1          synchronous clear of toggle_count
//   O             out  WIDTH      registered state
//   changed       out  1          registered: 1 iff the last edge altered O
//   toggle_count  out  CNT_WIDTH  saturating count of effective INVERT ops
//   count_sat     out  1          1 iff toggle_count == 2^CNT_WIDTH-1
//
// BEHAVIOUR
//   - Reset is synchronous and active-high on CLK. RESET=1 at an edge gives:
//     O=INIT, changed=0, toggle_count=0, count_sat=0.
//   - RESET overrides en, mode and cnt_clr.
//   - en=0 at an edge: O and toggle_count hold; changed<=0.
//   - en=1 at an edge, next O by mode:
//     HOLD   : O
//     INVERT : O ^ mask
//     LOAD   : (O & ~mask) | (load_data & mask)
//     ROTATE : {O[WIDTH-2:0], O[WIDTH-1]}  (rotate left by 1; WIDTH=1 -> unchanged)
//   - Latency: inputs are sampled at edge N; O reflects them after edge N.
//     No combinational path from any input to any output.
//   - changed <= (next O != current O). This is a value compare, so:
//     INVERT with mask=0 -> 0; LOAD of identical bits -> 0; ROTATE of all-0/all-1 -> 0.
//   - toggle_count, evaluated in priority order at each edge:
//     1. cnt_clr=1 -> 0. Clear wins over a simultaneous increment, independent of en.
//     2. Otherwise, en=1 && mode==01 && mask!=0 -> +1, saturating at 2^CNT_WIDTH-1. Never wraps.
//     3. Otherwise hold.
//   - count_sat is registered alongside toggle_count; it is never high while the count is below max.
//   - Reset mid-operation: the pending op is discarded; no partial update.
//
// TESTING  (WIDTH=8, INIT=8'hA5, CNT_WIDTH=8 unless stated)
//   1. RESET=1 for 2 edges with en=1, mode=01, mask=FF
//      -> O=A5, changed=0, toggle_count=0, count_sat=0.
//   2. en=1, mode=01, mask=FF for 2 edges
//      -> O=5A, changed=1, count=1; then O=A5, changed=1, count=2.
//      en=0 at the next edge -> all state held, changed=0.
//   3. From O=A5: mode=10, mask=0F, load_data=33 -> O=A3, changed=1.
//      Repeat the same op -> O=A3, changed=0.
//   4. Load O=81, then mode=11 -> O=03, then O=06.
//      O=FF rotate -> changed=0. WIDTH=1 build: rotate leaves O unchanged.
//   5. CNT_WIDTH=2: 5 INVERTs with mask=01 -> count 1,2,3,3,3; count_sat=1 from the 3rd.
//      Then cnt_clr=1 with a simultaneous INVERT -> count=0, count_sat=0, O still inverted.
//      INVERT with mask=00 -> count unchanged.
//   6. RESET asserted in the same cycle as LOAD of 00
//      -> O=A5 (INIT), toggle_count=0; LOAD is not applied.

Source files
------------

// File: rtl/toggle_reg_bank.sv
// WIDTH-bit control/status flop bank with masked invert/load, rotate-left,
// a value-change flag and a saturating count of effective invert operations.
module toggle_reg_bank #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  INIT      = '0,
  parameter int                CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     mask,
  input  logic [WIDTH-1:0]     load_data,
  input  logic                 cnt_clr,
  output logic [WIDTH-1:0]     O,
  output logic                 changed,
  output logic [CNT_WIDTH-1:0] toggle_count,
  output logic                 count_sat
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_INVERT = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_ROTATE = 2'b11
  } mode_t;

  logic [WIDTH-1:0]     r_o;
  logic                 r_changed;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_sat;

  logic [WIDTH-1:0]     w_rot;
  logic [WIDTH-1:0]     w_o_next;
  logic                 w_inc;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  // A single-bit bank has nothing to rotate into; it simply holds.
  generate
    if (WIDTH == 1) begin : g_rot_w1
      assign w_rot = r_o;
    end else begin : g_rot_wn
      assign w_rot = {r_o[WIDTH-2:0], r_o[WIDTH-1]};
    end
  endgenerate

  always_comb begin
    w_o_next = r_o;
    if (en) begin
      case (mode_t'(mode))
        MODE_HOLD:   w_o_next = r_o;
        MODE_INVERT: w_o_next = r_o ^ mask;
        MODE_LOAD:   w_o_next = (r_o & ~mask) | (load_data & mask);
        MODE_ROTATE: w_o_next = w_rot;
        default:     w_o_next = r_o;
      endcase
    end
  end

  // Only an invert that actually flips at least one bit counts as an event.
  assign w_inc = en && (mode_t'(mode) == MODE_INVERT) && (|mask);

  always_comb begin
    w_cnt_next = r_cnt;
    if (cnt_clr) begin
      w_cnt_next = '0;
    end else if (w_inc && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_o       <= INIT;
      r_changed <= 1'b0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_o       <= w_o_next;
      r_changed <= (w_o_next != r_o);
      r_cnt     <= w_cnt_next;
      r_sat     <= (w_cnt_next == CNT_MAX);
    end
  end

  assign O            = r_o;
  assign changed      = r_changed;
  assign toggle_count = r_cnt;
  assign count_sat    = r_sat;

endmodule

// File: tb/tb_toggle_reg_bank.sv
// Self-checking bench: three builds (8/8, 8/2-bit counter, 1-bit) driven in
// lockstep and compared against an arithmetic reference model every cycle.
module tb_toggle_reg_bank;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [1:0] mode;
  logic [7:0] mask, ld;

  logic [7:0] d8_o;  logic d8_ch; logic [7:0] d8_cnt; logic d8_sat;
  logic [7:0] d2_o;  logic d2_ch; logic [1:0] d2_cnt; logic d2_sat;
  logic [0:0] d1_o;  logic d1_ch; logic [7:0] d1_cnt; logic d1_sat;

  always #5 clk = ~clk;

  toggle_reg_bank #(.WIDTH(8), .INIT(8'hA5), .CNT_WIDTH(8)) u_d8 (
    .CLK(clk), .RESET(rst), .en(en), .mode(mode), .mask(mask), .load_data(ld),
    .cnt_clr(clr), .O(d8_o), .changed(d8_ch), .toggle_count(d8_cnt), .count_sat(d8_sat));

  toggle_reg_bank #(.WIDTH(8), .INIT(8'hA5), .CNT_WIDTH(2)) u_d2 (
    .CLK(clk), .RESET(rst), .en(en), .mode(mode), .mask(mask), .load_data(ld),
    .cnt_clr(clr), .O(d2_o), .changed(d2_ch), .toggle_count(d2_cnt), .count_sat(d2_sat));

  toggle_reg_bank #(.WIDTH(1), .INIT(1'b1), .CNT_WIDTH(8)) u_d1 (
    .CLK(clk), .RESET(rst), .en(en), .mode(mode), .mask(mask[0:0]), .load_data(ld[0:0]),
    .cnt_clr(clr), .O(d1_o), .changed(d1_ch), .toggle_count(d1_cnt), .count_sat(d1_sat));

  int total = 0;
  int bad   = 0;

  // Reference model state, one entry per build: 0 = d8, 1 = d2, 2 = d1.
  int m_o[3], m_ch[3], m_cnt[3];
  int m_w[3]    = '{8, 8, 1};
  int m_cw[3]   = '{8, 2, 8};
  int m_init[3] = '{32'hA5, 32'hA5, 1};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int next_o(input int o, input int w, input int md, input int mk, input int d);
    int wm = (1 << w) - 1;
    int r;
    case (md)
      0:       r = o;
      1:       r = o ^ mk;
      2:       r = (o & ~mk) | (d & mk);
      default: r = (w == 1) ? o : ((o << 1) | (o >> (w - 1)));
    endcase
    return r & wm;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int wm  = (1 << m_w[k]) - 1;
      int mx  = (1 << m_cw[k]) - 1;
      int mk  = int'(mask) & wm;
      int n;
      if (rst) begin
        m_o[k] = m_init[k]; m_ch[k] = 0; m_cnt[k] = 0;
      end else begin
        n = en ? next_o(m_o[k], m_w[k], int'(mode), mk, int'(ld) & wm) : m_o[k];
        m_ch[k] = (n != m_o[k]) ? 1 : 0;
        m_o[k]  = n;
        if (clr) m_cnt[k] = 0;
        else if (en && mode == 2'b01 && mk != 0) m_cnt[k] = (m_cnt[k] < mx) ? m_cnt[k] + 1 : mx;
      end
    end
  endtask

  task automatic compare_model();
    chk("d8.O",   int'(d8_o),   m_o[0]);   chk("d8.changed", int'(d8_ch), m_ch[0]);
    chk("d8.cnt", int'(d8_cnt), m_cnt[0]); chk("d8.sat", int'(d8_sat), (m_cnt[0] == 255) ? 1 : 0);
    chk("d2.O",   int'(d2_o),   m_o[1]);   chk("d2.changed", int'(d2_ch), m_ch[1]);
    chk("d2.cnt", int'(d2_cnt), m_cnt[1]); chk("d2.sat", int'(d2_sat), (m_cnt[1] == 3) ? 1 : 0);
    chk("d1.O",   int'(d1_o),   m_o[2]);   chk("d1.changed", int'(d1_ch), m_ch[2]);
    chk("d1.cnt", int'(d1_cnt), m_cnt[2]); chk("d1.sat", int'(d1_sat), (m_cnt[2] == 255) ? 1 : 0);
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] md,
                      input logic [7:0] mk, input logic [7:0] d, input logic c);
    rst = r; en = e; mode = md; mask = mk; ld = d; clr = c;
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic r, e; logic [1:0] md; logic [7:0] mk, d; logic c;
    logic [7:0] xo; logic xch; logic [7:0] xcnt; logic xsat;
  } vec_t;

  vec_t vt[18];

  initial begin
    vt[0]  = '{1, 1, 2'b01, 8'hFF, 8'h00, 0, 8'hA5, 0, 0, 0};
    vt[1]  = '{1, 1, 2'b01, 8'hFF, 8'h00, 0, 8'hA5, 0, 0, 0};
    vt[2]  = '{0, 1, 2'b01, 8'hFF, 8'h00, 0, 8'h5A, 1, 1, 0};
    vt[3]  = '{0, 1, 2'b01, 8'hFF, 8'h00, 0, 8'hA5, 1, 2, 0};
    vt[4]  = '{0, 0, 2'b01, 8'hFF, 8'h00, 0, 8'hA5, 0, 2, 0};
    vt[5]  = '{0, 1, 2'b10, 8'h0F, 8'h33, 0, 8'hA3, 1, 2, 0};
    vt[6]  = '{0, 1, 2'b10, 8'h0F, 8'h33, 0, 8'hA3, 0, 2, 0};
    vt[7]  = '{0, 1, 2'b10, 8'hFF, 8'h81, 0, 8'h81, 1, 2, 0};
    vt[8]  = '{0, 1, 2'b11, 8'h00, 8'h00, 0, 8'h03, 1, 2, 0};
    vt[9]  = '{0, 1, 2'b11, 8'hFF, 8'h00, 0, 8'h06, 1, 2, 0};
    vt[10] = '{0, 1, 2'b10, 8'hFF, 8'hFF, 0, 8'hFF, 1, 2, 0};
    vt[11] = '{0, 1, 2'b11, 8'h00, 8'h00, 0, 8'hFF, 0, 2, 0};
    vt[12] = '{0, 1, 2'b01, 8'h00, 8'h00, 0, 8'hFF, 0, 2, 0};
    vt[13] = '{0, 1, 2'b00, 8'hFF, 8'h00, 0, 8'hFF, 0, 2, 0};
    vt[14] = '{1, 1, 2'b10, 8'hFF, 8'h00, 0, 8'hA5, 0, 0, 0};
    vt[15] = '{0, 1, 2'b01, 8'h01, 8'h00, 0, 8'hA4, 1, 1, 0};
    vt[16] = '{0, 0, 2'b01, 8'h01, 8'h00, 1, 8'hA4, 0, 0, 0};
    vt[17] = '{0, 1, 2'b01, 8'h02, 8'h00, 1, 8'hA6, 1, 0, 0};

    for (int i = 0; i < 18; i++) begin
      step(vt[i].r, vt[i].e, vt[i].md, vt[i].mk, vt[i].d, vt[i].c);
      chk($sformatf("vec%0d.O", i),   int'(d8_o),   int'(vt[i].xo));
      chk($sformatf("vec%0d.ch", i),  int'(d8_ch),  int'(vt[i].xch));
      chk($sformatf("vec%0d.cnt", i), int'(d8_cnt), int'(vt[i].xcnt));
      chk($sformatf("vec%0d.sat", i), int'(d8_sat), int'(vt[i].xsat));
      $display("vec %0d: O=%02h changed=%0d count=%0d sat=%0d", i, d8_o, d8_ch, d8_cnt, d8_sat);
    end

    // 2-bit counter saturation, then clear racing an invert.
    step(1, 0, 2'b00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 2'b01, 8'h01, 8'h00, 0);
      chk($sformatf("sat%0d.cnt", i), int'(d2_cnt), (i < 3) ? i + 1 : 3);
      chk($sformatf("sat%0d.flag", i), int'(d2_sat), (i >= 2) ? 1 : 0);
      $display("sat %0d: count=%0d sat=%0d O=%02h", i, d2_cnt, d2_sat, d2_o);
    end
    step(0, 1, 2'b01, 8'h01, 8'h00, 1);
    chk("clr.cnt", int'(d2_cnt), 0); chk("clr.sat", int'(d2_sat), 0); chk("clr.O", int'(d2_o), 8'hA5);
    $display("clr+inv: count=%0d sat=%0d O=%02h", d2_cnt, d2_sat, d2_o);
    step(0, 1, 2'b01, 8'h01, 8'h00, 0);
    step(0, 1, 2'b01, 8'h00, 8'h00, 0);
    chk("mask0.cnt", int'(d2_cnt), 1); chk("mask0.ch", int'(d2_ch), 0);
    $display("inv mask0: count=%0d changed=%0d", d2_cnt, d2_ch);

    // Single-bit build: rotate must not alter the bit.
    step(0, 1, 2'b10, 8'h01, 8'h01, 0);
    step(0, 1, 2'b11, 8'h00, 8'h00, 0);
    chk("w1rot.O", int'(d1_o), 1); chk("w1rot.ch", int'(d1_ch), 0);
    $display("w1 rotate: O=%0d changed=%0d", d1_o, d1_ch);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
      $display("rand %0d: rst=%0d en=%0d mode=%0d mask=%02h ld=%02h clr=%0d -> O=%02h cnt=%0d cnt2=%0d",
               i, rst, en, mode, mask, ld, clr, d8_o, d8_cnt, d2_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
